// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with mid-bit sampling and stop-bit checking.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic       uart_rx_done,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic            rx_meta_reg;
  logic            rx_sync_reg;
  logic            rx_sync_d_reg;
`ifdef UART_RX_PARITY_EN
  logic            par_err_reg;
`endif

  assign uart_rx_busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      bit_idx_reg       <= '0;
      shift_reg         <= '0;
      rx_meta_reg       <= 1'b1;
      rx_sync_reg       <= 1'b1;
      rx_sync_d_reg     <= 1'b1;
      uart_rx_data_o    <= '0;
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_reg       <= 1'b0;
`endif
    end else begin
      rx_meta_reg       <= uart_rxd;
      rx_sync_reg       <= rx_meta_reg;
      rx_sync_d_reg     <= rx_sync_reg;
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      // Saturating count; every branch below that samples a bit clears it.
      if (cnt_reg != CNT_LAST)
        cnt_reg <= cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_sync_reg && rx_sync_d_reg)
            state_reg <= START;
        end
        START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rx_sync_reg ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg     <= '0;
            par_err_reg <= ^{shift_reg, rx_sync_reg};
            state_reg   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
            if (rx_sync_reg && !par_err_reg) begin
`else
            if (rx_sync_reg) begin
`endif
              uart_rx_data_o <= shift_reg;
              uart_rx_done   <= 1'b1;
            end else begin
              uart_rx_frame_err <= 1'b1;
            end
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
